// File: rtl/complex_alu_issue_pkg.sv
// Shared constants and control-word helpers for the complex_alu issue/retire controller.
package complex_alu_issue_pkg;

  localparam int ALUMODE_WIDTH = 4;
  localparam int INMODE_WIDTH  = 5;
  localparam int OPMODE_WIDTH  = 7;
  localparam int DATA_WIDTH    = 32;
  localparam int NUM_CORES     = 4;

  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_ADD    = 4'b0000;
  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_ZMINUS = 4'b0011;
  localparam logic [OPMODE_WIDTH-1:0]  OPMODE_MUL     = 7'b0000101;
  localparam logic [INMODE_WIDTH-1:0]  INMODE_A2B2    = 5'b00000;

  typedef logic [DATA_WIDTH-1:0] data_t;

  // Conjugate multiply negates the products feeding cores 2 and 4 (core 1 is the MSB word).
  function automatic logic [NUM_CORES*ALUMODE_WIDTH-1:0] alumode_word(input logic conj);
    logic [NUM_CORES*ALUMODE_WIDTH-1:0] w;
    if (conj) begin
      w = {ALUMODE_ADD, ALUMODE_ZMINUS, ALUMODE_ADD, ALUMODE_ZMINUS};
    end else begin
      w = {NUM_CORES{ALUMODE_ADD}};
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_count == {CW{1'b0}});
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_rd    = i_rd_en && !o_empty;
  // A full FIFO may still accept when the head leaves on the same edge.
  assign w_wr    = i_wr_en && (!w_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/complex_alu_issue.sv
// Issue/retire controller for complex_alu: decodes operations into DSP control words,
// tags them through the fixed ALU latency and buffers results behind a credit-checked FIFO.
module complex_alu_issue
  import complex_alu_issue_pkg::*;
#(
  parameter int ALU_LAT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_op_conj,
  input  logic [31:0] s_x,
  input  logic [31:0] s_y,
  output logic [15:0] alumode,
  output logic [19:0] inmode,
  output logic [27:0] opmode,
  output logic [3:0]  cea2,
  output logic [3:0]  ceb2,
  output logic [3:0]  usemult,
  output logic [31:0] din_1,
  output logic [31:0] din_2,
  input  logic [31:0] alu_dout,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W = $clog2(FIFO_DEPTH + ALU_LAT + 1) + 1;

  logic [ALU_LAT-1:0] r_track;
  logic [15:0]        r_alumode;
  logic [19:0]        r_inmode;
  logic [27:0]        r_opmode;
  logic [3:0]         r_cea2;
  logic [3:0]         r_ceb2;
  logic [3:0]         r_usemult;
  data_t              r_din_1;
  data_t              r_din_2;

  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_fifo_count;
  logic [CRD_W-1:0]   w_inflight;
  logic [CRD_W-1:0]   w_credit;

  assign w_issue = s_valid && s_ready;
  assign w_push  = r_track[ALU_LAT-1];
  assign w_pop   = m_valid && m_ready;

  always_comb begin
    w_inflight = {CRD_W{1'b0}};
    for (int i = 0; i < ALU_LAT; i++) begin
      w_inflight = w_inflight + CRD_W'(r_track[i]);
    end
  end

  // Every in-flight op already owns a FIFO slot, so a push can never be refused.
  assign w_credit = w_inflight + CRD_W'(w_fifo_count);
  assign s_ready  = (w_credit < CRD_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_track <= {ALU_LAT{1'b0}};
    end else begin
      r_track <= (r_track << 1) | ALU_LAT'(w_issue);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alumode <= 16'h0000;
      r_inmode  <= 20'h00000;
      r_opmode  <= 28'h0000000;
      r_cea2    <= 4'h0;
      r_ceb2    <= 4'h0;
      r_usemult <= 4'h0;
      r_din_1   <= 32'h0000_0000;
      r_din_2   <= 32'h0000_0000;
    end else if (w_issue) begin
      r_alumode <= alumode_word(s_op_conj);
      r_inmode  <= {NUM_CORES{INMODE_A2B2}};
      r_opmode  <= {NUM_CORES{OPMODE_MUL}};
      r_cea2    <= 4'hF;
      r_ceb2    <= 4'hF;
      r_usemult <= 4'hF;
      r_din_1   <= s_x;
      r_din_2   <= s_y;
    end else begin
      r_cea2    <= 4'h0;
      r_ceb2    <= 4'h0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .i_rst_n   (rst),
    .i_wr_en   (w_push),
    .i_wr_data (alu_dout),
    .i_rd_en   (w_pop),
    .o_rd_data (m_data),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign m_valid = !w_fifo_empty;
  assign alumode = r_alumode;
  assign inmode  = r_inmode;
  assign opmode  = r_opmode;
  assign cea2    = r_cea2;
  assign ceb2    = r_ceb2;
  assign usemult = r_usemult;
  assign din_1   = r_din_1;
  assign din_2   = r_din_2;

endmodule

// File: tb/tb_complex_alu_issue.sv
// Self-checking bench for complex_alu_issue with a behavioural complex_alu and a queue-based reference.
module tb_complex_alu_issue;

  localparam int ALU_LAT = 4;
  localparam int DEPTH   = 8;
  localparam logic [27:0] OPM4 = {4{7'b0000101}};

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic        s_op_conj;
  logic [31:0] s_x;
  logic [31:0] s_y;
  logic [15:0] alumode;
  logic [19:0] inmode;
  logic [27:0] opmode;
  logic [3:0]  cea2;
  logic [3:0]  ceb2;
  logic [3:0]  usemult;
  logic [31:0] din_1;
  logic [31:0] din_2;
  logic [31:0] alu_dout;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;

  complex_alu_issue #(.ALU_LAT(ALU_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_op_conj(s_op_conj),
    .s_x(s_x), .s_y(s_y), .alumode(alumode), .inmode(inmode), .opmode(opmode),
    .cea2(cea2), .ceb2(ceb2), .usemult(usemult), .din_1(din_1), .din_2(din_2),
    .alu_dout(alu_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural complex_alu: four multiplier cores, optional negation, i = p1 - p2, q = p3 + p4.
  function automatic logic [31:0] alu_f(logic [31:0] d1, logic [31:0] d2, logic [15:0] am);
    int a, b, c, d, p1, p2, p3, p4, i_v, q_v;
    a = int'($signed(d1[31:16])); b = int'($signed(d1[15:0]));
    c = int'($signed(d2[31:16])); d = int'($signed(d2[15:0]));
    p1 = a * c; p2 = b * d; p3 = b * c; p4 = a * d;
    if (am[15:12] == 4'b0011) p1 = -p1;
    if (am[11:8]  == 4'b0011) p2 = -p2;
    if (am[7:4]   == 4'b0011) p3 = -p3;
    if (am[3:0]   == 4'b0011) p4 = -p4;
    i_v = p1 - p2;
    q_v = p3 + p4;
    return {i_v[15:0], q_v[15:0]};
  endfunction

  logic [31:0] alu_pipe [ALU_LAT-1];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(din_1, din_2, alumode);
    for (int k = 1; k < ALU_LAT - 1; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign alu_dout = alu_pipe[ALU_LAT-2];

  // Reference: plain complex multiply of the accepted operands.
  function automatic logic [31:0] ref_mul(logic [31:0] x, logic [31:0] y, logic conj);
    int a, b, c, d, re, im;
    a = int'($signed(x[31:16])); b = int'($signed(x[15:0]));
    c = int'($signed(y[31:16])); d = int'($signed(y[15:0]));
    if (conj) begin re = a*c + b*d; im = b*c - a*d; end
    else      begin re = a*c - b*d; im = a*d + b*c; end
    return {re[15:0], im[15:0]};
  endfunction

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  logic [31:0] exp_q [$];
  int          avail_q [$];
  bit          prev_issue = 1'b0;
  bit          any_issue = 1'b0;
  logic        last_conj = 1'b0;
  logic [31:0] last_x = 32'h0;
  logic [31:0] last_y = 32'h0;
  int          accepts;
  int          ready_drops;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check outputs against the model, update the model, advance to the next negedge.
  task automatic step();
    bit issue, exp_mv, pop;
    issue  = (s_valid === 1'b1) && (s_ready === 1'b1);
    exp_mv = (exp_q.size() > 0) && (avail_q[0] <= cyc);
    pop    = exp_mv && (m_ready === 1'b1);
    if (chk_en) begin
      chk("s_ready", 32'(s_ready), 32'(exp_q.size() < DEPTH));
      chk("m_valid", 32'(m_valid), 32'(exp_mv));
      if (exp_mv) chk("m_data", m_data, exp_q[0]);
      chk("cea2", 32'(cea2), prev_issue ? 32'hF : 32'h0);
      chk("ceb2", 32'(ceb2), prev_issue ? 32'hF : 32'h0);
      chk("usemult", 32'(usemult), any_issue ? 32'hF : 32'h0);
      chk("opmode", 32'(opmode), any_issue ? 32'(OPM4) : 32'h0);
      chk("inmode", 32'(inmode), 32'h0);
      chk("alumode", 32'(alumode), (any_issue && last_conj) ? 32'h0303 : 32'h0);
      chk("din_1", din_1, last_x);
      chk("din_2", din_2, last_y);
    end
    if (rst === 1'b0) begin
      exp_q.delete(); avail_q.delete();
      prev_issue = 1'b0; any_issue = 1'b0; last_conj = 1'b0;
      last_x = 32'h0; last_y = 32'h0;
    end else begin
      if (pop) begin void'(exp_q.pop_front()); void'(avail_q.pop_front()); end
      prev_issue = issue;
      if (issue) begin
        exp_q.push_back(ref_mul(s_x, s_y, s_op_conj));
        avail_q.push_back(cyc + ALU_LAT + 1);
        any_issue = 1'b1; last_conj = s_op_conj; last_x = s_x; last_y = s_y;
        accepts++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_rand();
    s_x = $urandom; s_y = $urandom; s_op_conj = 1'($urandom_range(1));
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_op_conj = 1'b0;
    s_x = 32'h0; s_y = 32'h0; accepts = 0; ready_drops = 0;
    @(negedge clk);
    step(); step();
    rst = 1'b1;
    chk_en = 1'b1;
    chk("rst_s_ready", 32'(s_ready), 32'h1);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_alumode", 32'(alumode), 32'h0);

    // Plain multiply
    m_ready = 1'b1; s_valid = 1'b1; s_op_conj = 1'b0;
    s_x = {16'd1, 16'd2}; s_y = {16'd3, 16'd4};
    step();
    s_valid = 1'b0;
    chk("plain_alumode", 32'(alumode), 32'h0000);
    chk("plain_cea2", 32'(cea2), 32'hF);
    for (int i = 0; i < ALU_LAT; i++) step();
    chk("plain_m_valid", 32'(m_valid), 32'h1);
    chk("plain_m_data", m_data, {16'hFFFB, 16'h000A});
    step();

    // Conjugate multiply
    s_valid = 1'b1; s_op_conj = 1'b1;
    step();
    s_valid = 1'b0;
    chk("conj_alumode", 32'(alumode), 32'h0303);
    for (int i = 0; i < ALU_LAT; i++) step();
    chk("conj_m_data", m_data, {16'd11, 16'd2});
    step(); step();

    // Backpressure: fill exactly DEPTH, then drain in order
    m_ready = 1'b0; s_valid = 1'b1; accepts = 0;
    for (int i = 0; i < 20; i++) begin drive_rand(); step(); end
    chk("bp_accepts", 32'(accepts), 32'(DEPTH));
    chk("bp_s_ready_low", 32'(s_ready), 32'h0);
    s_valid = 1'b0; m_ready = 1'b1;
    step();
    chk("bp_ready_after_pop", 32'(s_ready), 32'h1);
    for (int i = 0; i < DEPTH + 2; i++) step();
    chk("bp_drained", 32'(m_valid), 32'h0);

    // Streaming: 100 back-to-back ops
    s_valid = 1'b1; accepts = 0;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      if (s_ready !== 1'b1) ready_drops++;
      step();
    end
    s_valid = 1'b0;
    chk("stream_ready_drops", 32'(ready_drops), 32'h0);
    chk("stream_accepts", 32'(accepts), 32'd100);
    for (int i = 0; i < ALU_LAT + 3; i++) step();

    // Reset mid-flight
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin drive_rand(); step(); end
    s_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_alumode", 32'(alumode), 32'h0);
    chk("mrst_opmode", 32'(opmode), 32'h0);
    chk("mrst_usemult", 32'(usemult), 32'h0);
    chk("mrst_din_1", din_1, 32'h0);
    chk("mrst_m_data", m_data, 32'h0);
    for (int i = 0; i < ALU_LAT + 2; i++) begin
      chk("mrst_m_valid", 32'(m_valid), 32'h0);
      step();
    end

    // Random stalls
    for (int i = 0; i < 200; i++) begin
      s_valid = 1'($urandom_range(1));
      m_ready = 1'($urandom_range(1));
      drive_rand();
      step();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < DEPTH + ALU_LAT + 2; i++) step();
    chk("final_empty", 32'(m_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
